// File: rtl/int_ctrl_if.sv
// Interrupt controller bus: source/mask/ack inputs and the core-facing request outputs.
interface int_ctrl_if #(
    parameter int unsigned N_SRC = 4
);
    logic [N_SRC-1:0] src_i;
    logic             mask_wr_i;
    logic [N_SRC-1:0] mask_i;
    logic             ack_i;
    logic             int_o;
    logic [7:0]       data_o;
    logic             busy_o;
    logic [N_SRC-1:0] pending_o;

    modport master (
        output src_i, mask_wr_i, mask_i, ack_i,
        input  int_o, data_o, busy_o, pending_o
    );

    modport slave (
        input  src_i, mask_wr_i, mask_i, ack_i,
        output int_o, data_o, busy_o, pending_o
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt scheduler: captures source edges, masks them, grants one source round-robin
// and drives a pulsed request plus vector to the core until it acknowledges or times out.
module int_ctrl #(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [7:0]  VEC_BASE  = 8'h80
) (
    input logic        clk_i,
    input logic        rst_i,
    int_ctrl_if.slave  bus
);
    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [IW-1:0]    rr;
    logic [IW-1:0]    gnt_idx;
    logic [PW-1:0]    pulse_cnt;
    logic [TW-1:0]    timeout_cnt;
    logic             int_q;
    logic [7:0]       data_q;
    logic             busy_q;

    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] set_c;
    logic [N_SRC-1:0] clr_c;
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    cand;
    logic             ack_acc;

    assign elig    = pending & mask;
    assign set_c   = bus.src_i & ~src_prev;
    assign ack_acc = bus.ack_i && ((state == PULSE) || (state == WAIT));

    // Round-robin search starting one past the last served source.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IW'((32'(rr) + k) % N_SRC);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        clr_c = '0;
        if (ack_acc) clr_c[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            src_prev    <= '0;
            pending     <= '0;
            mask        <= '0;
            rr          <= '0;
            gnt_idx     <= '0;
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            int_q       <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            src_prev <= bus.src_i;
            // A new edge on the source being acknowledged keeps it pending.
            pending  <= (pending & ~clr_c) | set_c;
            if (bus.mask_wr_i) mask <= bus.mask_i;

            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= PULSE;
                        gnt_idx     <= pick;
                        pulse_cnt   <= '0;
                        timeout_cnt <= '0;
                        int_q       <= 1'b1;
                        data_q      <= VEC_BASE | 8'(pick);
                        busy_q      <= 1'b1;
                    end
                end
                PULSE: begin
                    if (bus.ack_i) begin
                        state  <= GAP;
                        rr     <= gnt_idx;
                        int_q  <= 1'b0;
                        data_q <= 8'h00;
                    end else if (pulse_cnt == PW'(PULSE_CYC - 1)) begin
                        state <= WAIT;
                        int_q <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                WAIT: begin
                    if (bus.ack_i) begin
                        state  <= GAP;
                        rr     <= gnt_idx;
                        data_q <= 8'h00;
                    end else if (timeout_cnt == TW'(TIMEOUT - 1)) begin
                        // Abandon without touching pending or rr so the source is retried.
                        state  <= GAP;
                        data_q <= 8'h00;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end
                GAP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_o     = int_q;
    assign bus.data_o    = data_q;
    assign bus.busy_o    = busy_q;
    assign bus.pending_o = pending;
endmodule
